// File: rtl/pipe_stage.sv
// Valid/ready pipeline register for PC + instruction with stall, flush and a starved-cycle counter.
// Optional macro PIPE_STAGE_SKID_EN selects a 2-entry main+skid buffer with a registered o_ready.
module pipe_stage #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [PC_W-1:0]   i_pc,
   input  logic [INST_W-1:0] i_inst,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [PC_W-1:0]   o_pc,
   output logic [INST_W-1:0] o_inst,
   input  logic              i_stall,
   input  logic              i_flush,
   output logic [CNT_W-1:0]  o_bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic valid_int;
   logic accept;
   logic drain;

   // Stall hides the held entry downstream and blocks upstream without touching storage.
   assign o_valid = valid_int & !i_stall;
   assign accept  = i_valid & o_ready;
   assign drain   = o_valid & i_ready;

`ifdef PIPE_STAGE_SKID_EN
   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

   state_t              state_q, state_d;
   logic                ready_q, ready_d;
   logic [PC_W-1:0]     main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
   logic [INST_W-1:0]   main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;

   // Registered readiness: no path from i_ready to o_ready.
   assign o_ready   = ready_q & !i_stall & !rst;
   assign valid_int = (state_q != ST_EMPTY);
   assign o_pc      = main_pc_q;
   assign o_inst    = main_inst_q;

   always_comb begin
      state_d     = state_q;
      main_pc_d   = main_pc_q;
      main_inst_d = main_inst_q;
      skid_pc_d   = skid_pc_q;
      skid_inst_d = skid_inst_q;
      if (i_flush) begin
         state_d     = ST_EMPTY;
         main_pc_d   = '0;
         main_inst_d = '0;
         skid_pc_d   = '0;
         skid_inst_d = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_pc_d   = i_pc;
                  main_inst_d = i_inst;
                  state_d     = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  main_pc_d   = i_pc;
                  main_inst_d = i_inst;
               end else if (accept) begin
                  skid_pc_d   = i_pc;
                  skid_inst_d = i_inst;
                  state_d     = ST_TWO;
               end else if (drain) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               // Promote the skid entry once the main entry leaves.
               if (drain) begin
                  main_pc_d   = skid_pc_q;
                  main_inst_d = skid_inst_q;
                  skid_pc_d   = '0;
                  skid_inst_d = '0;
                  state_d     = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      ready_d = (state_d != ST_TWO);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         ready_q     <= 1'b1;
         main_pc_q   <= '0;
         main_inst_q <= '0;
         skid_pc_q   <= '0;
         skid_inst_q <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         main_pc_q   <= main_pc_d;
         main_inst_q <= main_inst_d;
         skid_pc_q   <= skid_pc_d;
         skid_inst_q <= skid_inst_d;
      end
   end
`else
   logic                valid_q, valid_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [INST_W-1:0]   inst_q, inst_d;

   assign o_ready   = (!valid_q | i_ready) & !i_stall & !rst;
   assign valid_int = valid_q;
   assign o_pc      = pc_q;
   assign o_inst    = inst_q;

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      if (i_flush) begin
         valid_d = 1'b0;
         pc_d    = '0;
         inst_d  = '0;
      end else if (accept) begin
         valid_d = 1'b1;
         pc_d    = i_pc;
         inst_d  = i_inst;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         inst_q  <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
      end
   end
`endif

   // Starved-cycle counter: downstream ready, nothing to give, not stalled.
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (!valid_int && i_ready && !i_stall && (bubble_cnt_q != CNT_MAX))
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) bubble_cnt_q <= '0;
      else     bubble_cnt_q <= bubble_cnt_d;
   end

   assign o_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed self-checking bench for pipe_stage; expectations follow PIPE_STAGE_SKID_EN when defined.
module tb_pipe_stage;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned INST_W = 32;
   localparam int unsigned CNT_W  = 4;
`ifdef PIPE_STAGE_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              i_valid, o_ready, o_valid, i_ready, i_stall, i_flush;
   logic [PC_W-1:0]   i_pc, o_pc;
   logic [INST_W-1:0] i_inst, o_inst;
   logic [CNT_W-1:0]  o_bubble_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_stage #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc),
      .i_inst(i_inst), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
      .o_inst(o_inst), .i_stall(i_stall), .i_flush(i_flush), .o_bubble_cnt(o_bubble_cnt)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cyc(); cyc();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", o_valid); end
      checks++; if (o_pc !== '0) begin errors++; $display("FAIL rst_pc: got %h exp 0", o_pc); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", o_ready); end
      rst = 1'b0;
      i_valid = 1'b1; i_pc = 32'h100; i_inst = 32'h1111; i_ready = 1'b1;
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b exp 1", o_ready); end
      cyc();
      checks++; if (o_valid !== 1'b1 || o_pc !== 32'h100) begin errors++; $display("FAIL first_acc: got v=%b pc=%h exp v=1 pc=100", o_valid, o_pc); end
      // Assert reset mid-cycle while an entry is held and another is being offered
      i_pc = 32'h104; i_inst = 32'h1112;
      #3 rst = 1'b1;
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b exp 0", o_valid); end
      checks++; if (o_pc !== '0 || o_inst !== '0) begin errors++; $display("FAIL midrst_data: got pc=%h inst=%h exp 0", o_pc, o_inst); end
      checks++; if (o_bubble_cnt !== '0) begin errors++; $display("FAIL midrst_cnt: got %0d exp 0", o_bubble_cnt); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b exp 0", o_ready); end
      i_valid = 1'b0;
      cyc();
      rst = 1'b0;
      i_valid = 1'b1; i_pc = 32'h200; i_inst = 32'h2222;
      cyc();
      checks++; if (o_valid !== 1'b1 || o_pc !== 32'h200 || o_inst !== 32'h2222) begin errors++; $display("FAIL post_rst_acc: got v=%b pc=%h inst=%h exp v=1 pc=200 inst=2222", o_valid, o_pc, o_inst); end
      i_valid = 1'b0;
      cyc();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL post_rst_drain: got %b exp 0", o_valid); end
   endtask

   task automatic test_stream();
      i_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         i_valid = 1'b1; i_pc = PC_W'(4 * k); i_inst = INST_W'(32'h1000 + k);
         cyc();
         checks++;
         if (o_valid !== 1'b1 || o_pc !== PC_W'(4 * k) || o_inst !== INST_W'(32'h1000 + k)) begin
            errors++; $display("FAIL stream%0d: got v=%b pc=%h inst=%h exp v=1 pc=%h", k, o_valid, o_pc, o_inst, 4 * k);
         end
      end
      i_valid = 1'b0;
      cyc();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got %b exp 0", o_valid); end
   endtask

   task automatic test_backpressure();
      logic [PC_W-1:0] pc_tab [3];
      logic            exp_rdy [3];
      int              idx;
      pc_tab[0] = 32'h40; pc_tab[1] = 32'h44; pc_tab[2] = 32'h48;
      exp_rdy[0] = 1'b1; exp_rdy[1] = (DEPTH == 2); exp_rdy[2] = 1'b0;
      idx = 0;
      i_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         i_valid = 1'b1; i_pc = pc_tab[idx]; i_inst = INST_W'(idx);
         #1;
         checks++; if (o_ready !== exp_rdy[c]) begin errors++; $display("FAIL bp_ready%0d: got %b exp %b", c, o_ready, exp_rdy[c]); end
         if (exp_rdy[c]) idx++;
         cyc();
         checks++; if (o_valid !== 1'b1 || o_pc !== 32'h40) begin errors++; $display("FAIL bp_hold%0d: got v=%b pc=%h exp v=1 pc=40", c, o_valid, o_pc); end
      end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b exp 0", o_ready); end
      i_valid = 1'b0; i_ready = 1'b1;
      for (int e = 0; e < DEPTH; e++) begin
         #1;
         checks++; if (o_valid !== 1'b1 || o_pc !== pc_tab[e]) begin errors++; $display("FAIL bp_order%0d: got v=%b pc=%h exp v=1 pc=%h", e, o_valid, o_pc, pc_tab[e]); end
         cyc();
      end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b exp 0", o_valid); end
   endtask

   task automatic test_flush();
      i_ready = 1'b0;
      i_valid = 1'b1; i_pc = 32'h80; i_inst = 32'hA0; cyc();
      i_pc = 32'h84; i_inst = 32'hA4; cyc();
      i_flush = 1'b1; i_pc = 32'h88; i_inst = 32'hDEAD;
      cyc();
      checks++; if (o_valid !== 1'b0 || o_inst !== '0 || o_pc !== '0) begin errors++; $display("FAIL flush_full: got v=%b pc=%h inst=%h exp 0", o_valid, o_pc, o_inst); end
      i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost%0d: got %b exp 0", c, o_valid); end
         cyc();
      end
      // Flush on an empty stage must also discard the entry being accepted
      i_flush = 1'b1; i_valid = 1'b1; i_pc = 32'h8C; i_inst = 32'hBEEF;
      cyc();
      checks++; if (o_valid !== 1'b0 || o_inst !== '0) begin errors++; $display("FAIL flush_incoming: got v=%b inst=%h exp v=0 inst=0", o_valid, o_inst); end
      i_flush = 1'b0; i_valid = 1'b0;
      cyc();
   endtask

   task automatic test_stall();
      i_ready = 1'b0; i_valid = 1'b1; i_pc = 32'hC0; i_inst = 32'hC0C0;
      cyc();
      checks++; if (o_valid !== 1'b1 || o_pc !== 32'hC0) begin errors++; $display("FAIL stall_pre: got v=%b pc=%h exp v=1 pc=c0", o_valid, o_pc); end
      i_stall = 1'b1; i_pc = 32'hC4; i_inst = 32'hC4C4; i_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++; if (o_valid !== 1'b0 || o_ready !== 1'b0) begin errors++; $display("FAIL stall%0d: got v=%b r=%b exp 0 0", c, o_valid, o_ready); end
         cyc();
      end
      i_stall = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b1 || o_pc !== 32'hC0 || o_inst !== 32'hC0C0) begin errors++; $display("FAIL stall_back: got v=%b pc=%h exp v=1 pc=c0", o_valid, o_pc); end
      i_ready = 1'b1;
      cyc();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b exp 0", o_valid); end
   endtask

   task automatic test_bubble_sat();
      int exp_cnt;
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_flush = 1'b0; i_stall = 1'b0;
      cyc();
      rst = 1'b0;
      checks++; if (o_bubble_cnt !== '0) begin errors++; $display("FAIL cnt_zero: got %0d exp 0", o_bubble_cnt); end
      for (int k = 1; k <= 3; k++) begin
         cyc();
         checks++; if (o_bubble_cnt !== CNT_W'(k)) begin errors++; $display("FAIL cnt_inc%0d: got %0d exp %0d", k, o_bubble_cnt, k); end
      end
      i_ready = 1'b0; i_flush = 1'b1;
      cyc();
      checks++; if (o_bubble_cnt !== CNT_W'(3)) begin errors++; $display("FAIL cnt_flush: got %0d exp 3", o_bubble_cnt); end
      i_flush = 1'b0; i_ready = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         exp_cnt = (3 + k > 15) ? 15 : 3 + k;
         checks++; if (o_bubble_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL cnt_sat%0d: got %0d exp %0d", k, o_bubble_cnt, exp_cnt); end
      end
   endtask

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
      i_pc = '0; i_inst = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_stall();
      test_bubble_sat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32: PC field width in bits.
REQ-002 SHALL have parameter INST_W, default 32: instruction field width in bits.
REQ-003 SHALL have parameter CNT_W, default 16: bubble-counter width in bits.
REQ-004 SHALL have port clk  in  1: clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have port i_valid  in  1: upstream PC/instruction valid.
REQ-007 SHALL have port o_ready  out  1: stage can accept upstream data this cycle.
REQ-008 SHALL have port i_pc  in  PC_W: upstream PC.
REQ-009 SHALL have port i_inst  in  INST_W: upstream instruction.
REQ-010 SHALL have port o_valid  out  1: downstream data valid.
REQ-011 SHALL have port i_ready  in  1: downstream accepts data this cycle.
REQ-012 SHALL have port o_pc  out  PC_W: registered PC.
REQ-013 SHALL have port o_inst  out  INST_W: registered instruction.
REQ-014 SHALL have port i_stall  in  1: freeze the stage.
REQ-015 SHALL have port i_flush  in  1: discard all held and incoming entries.
REQ-016 SHALL have port o_bubble_cnt  out  CNT_W: saturating count of starved cycles.

Function
REQ-017 SHALL accept upstream data on a rising edge when i_valid=1 and o_ready=1.
REQ-018 SHALL transfer data downstream on a rising edge when o_valid=1 and i_ready=1.
REQ-019 SHALL give an accepted entry a latency of exactly 1 cycle from acceptance to o_valid=1.
REQ-020 SHALL present entries to downstream in acceptance order, with none lost or duplicated.
REQ-021 SHALL hold o_pc/o_inst stable while o_valid=1 and i_ready=0.
REQ-022 SHALL, while i_stall=1, change no storage, drive o_ready=0, and drive o_valid=0 combinationally; stored entries reappear when i_stall drops.
REQ-023 SHALL, on a cycle with i_flush=1, make all storage invalid and zero the data registers at the next edge.
REQ-024 SHALL give i_flush priority over i_stall and over a same-cycle upstream acceptance; the incoming entry is discarded.
REQ-025 SHALL, when o_valid=1 and i_ready=1 on the same edge as a new acceptance, replace the output entry with the new entry, with o_valid staying 1.
REQ-026 SHALL increment o_bubble_cnt on each edge where o_valid=0, i_ready=1 and i_stall=0.
REQ-027 SHALL saturate o_bubble_cnt at 2^CNT_W-1 with no wrap-around.
REQ-028 SHALL leave o_bubble_cnt unaffected by i_flush.

Reset
REQ-029 SHALL, on rst=1, immediately force o_valid=0, o_pc=0, o_inst=0, o_bubble_cnt=0, and all skid storage to invalid and zero.
REQ-030 SHALL, if reset is asserted mid-transfer, discard all in-flight entries, with no transfer completing on that edge.
REQ-031 SHALL drive o_ready=0 while rst=1.
REQ-032 SHALL allow acceptance from the first rising edge after rst deasserts.

Configuration
REQ-033 SHALL, with macro PIPE_STAGE_SKID_EN defined, use a 2-entry buffer (main + skid) with states EMPTY, ONE and TWO.
REQ-034 SHALL, with PIPE_STAGE_SKID_EN defined, drive o_ready from a register: 1 in EMPTY and ONE, 0 in TWO, with no combinational path from i_ready.
REQ-035 SHALL, with PIPE_STAGE_SKID_EN defined, use these transitions: EMPTY->ONE on accept; ONE->TWO on accept without drain; TWO->ONE on drain; ONE->EMPTY on drain without accept; ONE stays ONE on simultaneous accept and drain.
REQ-036 SHALL, with PIPE_STAGE_SKID_EN defined, promote the skid entry to main on drain from TWO.
REQ-037 SHALL, without PIPE_STAGE_SKID_EN, use a single entry with o_ready = (!o_valid_reg | i_ready) & !i_stall & !rst, combinational.

Verification
REQ-038 SHALL cover: rst pulse mid-stream -> o_valid=0, o_pc=0, o_inst=0, o_bubble_cnt=0 immediately; first accept after release appears 1 cycle later.
REQ-039 SHALL cover: stream PC 0x0,0x4,0x8,0xC with i_ready=1 -> o_pc equals 0x0,0x4,0x8,0xC on consecutive cycles, 1-cycle latency.
REQ-040 SHALL cover: i_ready=0 for 3 cycles with i_valid=1 -> skid build holds 2 entries and o_ready=0; non-skid build holds 1 entry; order preserved after release.
REQ-041 SHALL cover: i_flush=1 with i_valid=1 and two stored entries -> next cycle o_valid=0 and o_inst=0; the incoming entry never appears.
REQ-042 SHALL cover: i_stall=1 for 2 cycles with o_valid held -> o_valid=0 and o_ready=0 during stall; the same PC reappears afterwards.
REQ-043 SHALL cover: CNT_W=4, i_valid=0, i_ready=1 for 20 cycles -> o_bubble_cnt saturates at 15.
